// File: rtl/riscv_div_sequencer.sv
// riscv_div_sequencer: holds divider operands for MCP_CYCLES, then registers the W-adjusted result with a one-cycle valid
// Optional one-entry result cache enabled by defining RISCV_DIVSEQ_RESULT_CACHE_EN
module riscv_div_sequencer #(
  parameter int MCP_CYCLES = 4
) (
  input  logic        i_riscv_divseq_clk,
  input  logic        i_riscv_divseq_rst,
  input  logic        i_riscv_divseq_start,
  input  logic [2:0]  i_riscv_divseq_divctrl,
  input  logic        i_riscv_divseq_wsel,
  input  logic [63:0] i_riscv_divseq_rs1data,
  input  logic [63:0] i_riscv_divseq_rs2data,
  input  logic        i_riscv_divseq_flush,
  output logic [2:0]  o_riscv_divseq_divctrl,
  output logic [63:0] o_riscv_divseq_div_rs1,
  output logic [63:0] o_riscv_divseq_div_rs2,
  input  logic [63:0] i_riscv_divseq_divresult,
  output logic [63:0] o_riscv_divseq_result,
  output logic        o_riscv_divseq_valid,
  output logic        o_riscv_divseq_stall
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        wsel_q, accept, capture, hit;
  logic [63:0] rs1_x, rs2_x, res_x, hit_res;
  assign accept  = i_riscv_divseq_start & i_riscv_divseq_divctrl[2] & ~i_riscv_divseq_flush & (state != WAIT);
  assign capture = (state == WAIT) & (cnt == 4'd0) & ~i_riscv_divseq_flush;
  assign rs1_x = ~i_riscv_divseq_wsel ? i_riscv_divseq_rs1data :
                 i_riscv_divseq_divctrl[0] ? {32'b0, i_riscv_divseq_rs1data[31:0]} :
                 {{32{i_riscv_divseq_rs1data[31]}}, i_riscv_divseq_rs1data[31:0]};
  assign rs2_x = ~i_riscv_divseq_wsel ? i_riscv_divseq_rs2data :
                 i_riscv_divseq_divctrl[0] ? {32'b0, i_riscv_divseq_rs2data[31:0]} :
                 {{32{i_riscv_divseq_rs2data[31]}}, i_riscv_divseq_rs2data[31:0]};
  assign res_x = wsel_q ? {{32{i_riscv_divseq_divresult[31]}}, i_riscv_divseq_divresult[31:0]} : i_riscv_divseq_divresult;
  assign o_riscv_divseq_stall = accept | (state == WAIT);
`ifdef RISCV_DIVSEQ_RESULT_CACHE_EN
  logic        c_vld, c_w;
  logic [2:0]  c_ctrl;
  logic [63:0] c_rs1, c_rs2, c_res;
  assign hit = c_vld & (c_ctrl == i_riscv_divseq_divctrl) & (c_w == i_riscv_divseq_wsel) & (c_rs1 == rs1_x) & (c_rs2 == rs2_x);
  assign hit_res = c_res;
  always_ff @(posedge i_riscv_divseq_clk)
    if (i_riscv_divseq_rst) begin
      c_vld  <= 1'b0;
      c_w    <= 1'b0;
      c_ctrl <= 3'd0;
      c_rs1  <= 64'd0;
      c_rs2  <= 64'd0;
      c_res  <= 64'd0;
    end else if (capture) begin
      c_vld  <= 1'b1;
      c_w    <= wsel_q;
      c_ctrl <= o_riscv_divseq_divctrl;
      c_rs1  <= o_riscv_divseq_div_rs1;
      c_rs2  <= o_riscv_divseq_div_rs2;
      c_res  <= res_x;
    end
`else
  assign hit = 1'b0;
  assign hit_res = 64'd0;
`endif
  always_ff @(posedge i_riscv_divseq_clk)
    if (i_riscv_divseq_rst) begin
      state                  <= IDLE;
      cnt                    <= 4'd0;
      wsel_q                 <= 1'b0;
      o_riscv_divseq_divctrl <= 3'd0;
      o_riscv_divseq_div_rs1 <= 64'd0;
      o_riscv_divseq_div_rs2 <= 64'd0;
      o_riscv_divseq_result  <= 64'd0;
      o_riscv_divseq_valid   <= 1'b0;
    end else begin
      o_riscv_divseq_valid <= capture | (accept & hit);
      if (i_riscv_divseq_flush)
        state <= IDLE;
      else if (accept) begin
        state                  <= hit ? DONE : WAIT;
        cnt                    <= 4'(MCP_CYCLES - 1);
        wsel_q                 <= i_riscv_divseq_wsel;
        o_riscv_divseq_divctrl <= i_riscv_divseq_divctrl;
        o_riscv_divseq_div_rs1 <= rs1_x;
        o_riscv_divseq_div_rs2 <= rs2_x;
        if (hit) o_riscv_divseq_result <= hit_res;
      end else if (state == WAIT) begin
        if (cnt == 4'd0) begin
          state                 <= DONE;
          o_riscv_divseq_result <= res_x;
        end else
          cnt <= cnt - 4'd1;
      end else
        state <= IDLE;
    end
endmodule

// File: tb/tb_riscv_div_sequencer.sv
// tb_riscv_div_sequencer: scoreboard bench with a behavioural divider behind the sequencer
module tb_riscv_div_sequencer;
  localparam int MCP = 4;
  logic        clk = 0, rst = 1, start = 0, wsel = 0, flush = 0;
  logic [2:0]  divctrl = 0, o_ctrl;
  logic [63:0] rs1 = 0, rs2 = 0, o_rs1, o_rs2, divresult, result, prev;
  logic        valid, stall;
  int          n_chk = 0, n_fail = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_div_sequencer #(.MCP_CYCLES(MCP)) dut (
    .i_riscv_divseq_clk(clk), .i_riscv_divseq_rst(rst), .i_riscv_divseq_start(start),
    .i_riscv_divseq_divctrl(divctrl), .i_riscv_divseq_wsel(wsel),
    .i_riscv_divseq_rs1data(rs1), .i_riscv_divseq_rs2data(rs2), .i_riscv_divseq_flush(flush),
    .o_riscv_divseq_divctrl(o_ctrl), .o_riscv_divseq_div_rs1(o_rs1), .o_riscv_divseq_div_rs2(o_rs2),
    .i_riscv_divseq_divresult(divresult), .o_riscv_divseq_result(result),
    .o_riscv_divseq_valid(valid), .o_riscv_divseq_stall(stall)
  );

  function automatic logic [63:0] div64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb, q;
    sa = a;
    sb = b;
    if (b == 64'd0) return op[1] ? a : '1;
    if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) return op[1] ? 64'd0 : a;
    if (op == 2'd0) q = sa / sb;
    else if (op == 2'd1) q = a / b;
    else if (op == 2'd2) q = sa % sb;
    else q = a % b;
    return q;
  endfunction

  function automatic logic [31:0] div32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == '1) return op[1] ? 32'd0 : a;
    if (op == 2'd0) q = sa / sb;
    else if (op == 2'd1) q = a / b;
    else if (op == 2'd2) q = sa % sb;
    else q = a % b;
    return q;
  endfunction

  function automatic logic [63:0] ref_op(input logic [2:0] c, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] r;
    r = div32(c[1:0], a[31:0], b[31:0]);
    return w ? {{32{r[31]}}, r} : div64(c[1:0], a, b);
  endfunction

  assign divresult = div64(o_ctrl[1:0], o_rs1, o_rs2);

  always @(negedge clk)
    if (!rst && valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid result=%h", result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          n_fail++;
          $display("FAIL scoreboard_result got=%h exp=%h", result, e);
        end
      end
    end

  task automatic issue(input logic [2:0] c, input logic w, input logic [63:0] a, input logic [63:0] b, input bit done);
    start = 1; divctrl = c; wsel = w; rs1 = a; rs2 = b;
    if (done) exp_q.push_back(ref_op(c, w, a, b));
    #1;
    n_chk++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_accept got=%b exp=1", stall); end
    @(negedge clk);
    start = 0; divctrl = 0;
    #1;
  endtask

  task automatic wait_done(input int want);
    logic [63:0] h1, h2;
    logic [2:0]  hc;
    int lat;
    h1 = o_rs1; h2 = o_rs2; hc = o_ctrl; lat = 1;
    while (valid !== 1'b1 && lat < 40) begin
      n_chk++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_wait cycle=%0d got=%b exp=1", lat, stall); end
      @(negedge clk); #1;
      lat++;
    end
    n_chk++;
    if (lat != want) begin n_fail++; $display("FAIL latency got=%0d exp=%0d", lat, want); end
    n_chk++;
    if (stall !== 1'b0 || {hc, h1, h2} !== {o_ctrl, o_rs1, o_rs2}) begin
      n_fail++; $display("FAIL done_hold stall=%b ctrl=%h rs1=%h rs2=%h exp ctrl=%h rs1=%h rs2=%h", stall, o_ctrl, o_rs1, o_rs2, hc, h1, h2);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_cycles(2);
    n_chk++;
    if ({o_ctrl, o_rs1, o_rs2, result, valid, stall} !== '0) begin
      n_fail++; $display("FAIL reset_state ctrl=%h rs1=%h rs2=%h res=%h v=%b s=%b exp all 0", o_ctrl, o_rs1, o_rs2, result, valid, stall);
    end
    rst = 0;
    idle_cycles(1);
  endtask

  task automatic test_div_signed;
    issue(3'b100, 0, -64'sd20, 64'd3, 1);
    wait_done(MCP + 1);
    n_chk++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL div_signed got=%h exp=fffffffffffffffa", result); end
    idle_cycles(1);
  endtask

  task automatic test_divw;
    issue(3'b100, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1);
    n_chk++;
    if (o_rs1 !== 64'hFFFF_FFFF_8000_0000 || o_rs2 !== '1) begin
      n_fail++; $display("FAIL divw_operands rs1=%h rs2=%h exp ffffffff80000000 ffffffffffffffff", o_rs1, o_rs2);
    end
    wait_done(MCP + 1);
    n_chk++;
    if (result !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL divw_result got=%h exp=ffffffff80000000", result); end
    idle_cycles(1);
  endtask

  task automatic test_remuw;
    issue(3'b111, 1, 64'h0000_0001_8000_0007, 64'd0, 1);
    n_chk++;
    if (o_rs1 !== 64'h0000_0000_8000_0007 || o_rs2 !== 64'd0) begin
      n_fail++; $display("FAIL remuw_operands rs1=%h rs2=%h exp 0000000080000007 0", o_rs1, o_rs2);
    end
    wait_done(MCP + 1);
    n_chk++;
    if (result !== 64'hFFFF_FFFF_8000_0007) begin n_fail++; $display("FAIL remuw_result got=%h exp=ffffffff80000007", result); end
    idle_cycles(1);
  endtask

  task automatic test_nondiv;
    start = 1; divctrl = 3'b011; rs1 = 64'd9; rs2 = 64'd2;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL nondiv_stall got=%b exp=0", stall); end
    @(negedge clk);
    start = 0; divctrl = 0;
    #1;
    n_chk++;
    if (o_ctrl !== 3'b111 || stall !== 1'b0) begin n_fail++; $display("FAIL nondiv_ignored ctrl=%b stall=%b exp 111 0", o_ctrl, stall); end
    idle_cycles(2);
  endtask

  task automatic test_flush;
    prev = result;
    issue(3'b101, 0, 64'd100, 64'd7, 0);
    @(negedge clk);
    flush = 1;
    #1;
    n_chk++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_wait_stall got=%b exp=1", stall); end
    @(negedge clk);
    flush = 0;
    #1;
    n_chk++;
    if (stall !== 1'b0 || valid !== 1'b0 || result !== prev) begin
      n_fail++; $display("FAIL flush_abort stall=%b valid=%b res=%h exp 0 0 %h", stall, valid, result, prev);
    end
    idle_cycles(6);
    issue(3'b101, 0, 64'd100, 64'd7, 1);
    wait_done(MCP + 1);
    n_chk++;
    if (result !== 64'd14) begin n_fail++; $display("FAIL flush_recover got=%h exp=e", result); end
    idle_cycles(1);
  endtask

  task automatic test_flush_start;
    start = 1; flush = 1; divctrl = 3'b100; rs1 = 64'd40; rs2 = 64'd8;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_start_stall got=%b exp=0", stall); end
    @(negedge clk);
    start = 0; flush = 0; divctrl = 0;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_start_dropped stall=%b exp=0", stall); end
    idle_cycles(6);
  endtask

  task automatic test_flush_capture;
    prev = result;
    issue(3'b110, 0, 64'd9, 64'd4, 0);
    repeat (MCP - 1) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    n_chk++;
    if (valid !== 1'b0 || result !== prev || stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_capture valid=%b res=%h stall=%b exp 0 %h 0", valid, result, stall, prev);
    end
    idle_cycles(4);
  endtask

  task automatic test_back_to_back;
    issue(3'b100, 0, 64'd100, 64'd9, 1);
    wait_done(MCP + 1);
    issue(3'b110, 0, 64'd17, 64'd5, 1);
    wait_done(MCP + 1);
    n_chk++;
    if (result !== 64'd2) begin n_fail++; $display("FAIL back_to_back got=%h exp=2", result); end
    idle_cycles(1);
  endtask

  task automatic test_table;
    issue(3'b100, 0, 64'h8000_0000_0000_0000, '1, 1);
    wait_done(MCP + 1);
    issue(3'b110, 0, 64'h8000_0000_0000_0000, '1, 1);
    wait_done(MCP + 1);
    issue(3'b110, 0, 64'd123, 64'd0, 1);
    wait_done(MCP + 1);
    issue(3'b101, 1, 64'hDEAD_0000_0000_0009, 64'd0, 1);
    wait_done(MCP + 1);
    for (int i = 0; i < 8; i++) begin
      issue({1'b1, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {32'($urandom_range(0, 1) * $urandom), $urandom_range(0, 99)}, 1);
      wait_done(MCP + 1);
    end
    idle_cycles(1);
  endtask

`ifdef RISCV_DIVSEQ_RESULT_CACHE_EN
  task automatic test_cache;
    issue(3'b100, 0, -64'sd20, 64'd3, 1);
    wait_done(MCP + 1);
    idle_cycles(1);
    issue(3'b100, 0, -64'sd20, 64'd3, 1);
    wait_done(1);
    n_chk++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL cache_hit got=%h exp=fffffffffffffffa", result); end
    rst = 1;
    idle_cycles(1);
    rst = 0;
    issue(3'b100, 0, -64'sd20, 64'd3, 1);
    wait_done(MCP + 1);
    idle_cycles(1);
  endtask
`endif

  task automatic test_reset_mid;
    issue(3'b100, 0, 64'd50, 64'd5, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    n_chk++;
    if ({result, valid, stall, o_rs1, o_ctrl} !== '0) begin
      n_fail++; $display("FAIL reset_mid res=%h v=%b s=%b rs1=%h ctrl=%b exp all 0", result, valid, stall, o_rs1, o_ctrl);
    end
    idle_cycles(6);
  endtask

  initial begin
    @(negedge clk); #1;
    test_reset;
    test_div_signed;
    test_divw;
    test_remuw;
    test_nondiv;
    test_flush;
    test_flush_start;
    test_flush_capture;
    test_back_to_back;
    test_table;
`ifdef RISCV_DIVSEQ_RESULT_CACHE_EN
    test_cache;
`endif
    test_reset_mid;
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
